mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data port share one
// fixed-latency memory; data has priority, bounded by a starvation streak limit.
module mem_arbiter #(
  parameter int LATENCY     = 2,  // 1..15
  parameter int MAX_DSTREAK = 3   // 1..15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_access_type,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_wren,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_access_type,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        owner_d
);

  // state | meaning
  // IDLE  | no transaction; arbitrate and capture the winner's request
  // ISSUE | single-cycle memory strobe with the captured request
  // WAIT  | count down the memory latency; pulse owner's ready at zero
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [3:0] WAIT_LOAD  = 4'(LATENCY - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);
  localparam logic [2:0] TYPE_WORD  = 3'b010;

  logic [1:0]  state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_nx;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  type_q, type_d;

  logic d_win;
  logic done;

  // Data wins a contested arbitration unless the fetch has waited out a full streak.
  assign d_win = d_req & ~(i_req & (streak_q == STREAK_MAX));

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    cnt_d    = cnt_q;
    owner_nx = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    type_d   = type_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req | d_req) begin
          state_d  = ST_ISSUE;
          owner_nx = d_win;
          if (d_win) begin
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            type_d  = d_access_type;
            if (i_req)
              streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
            else
              streak_d = 4'd0;
          end else begin
            we_d     = 1'b0;
            addr_d   = i_addr;
            wdata_d  = 32'h0;
            type_d   = TYPE_WORD;
            streak_d = 4'd0;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = WAIT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      streak_q <= 4'd0;
      cnt_q    <= 4'd0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      type_q   <= 3'b000;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_nx;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      type_q   <= type_d;
    end
  end

  // Reset in the final WAIT cycle must suppress the completion pulse.
  assign done = (state_q == ST_WAIT) & (cnt_q == 4'd0) & ~reset;

  assign busy            = (state_q == ST_ISSUE) | (state_q == ST_WAIT);
  assign owner_d         = busy & owner_q;
  assign mem_en          = (state_q == ST_ISSUE);
  assign mem_wren        = mem_en & we_q;
  assign mem_addr        = busy ? addr_q  : 32'h0;
  assign mem_wdata       = busy ? wdata_q : 32'h0;
  assign mem_access_type = busy ? type_q  : 3'b000;

  assign i_ready = done & ~owner_q;
  assign d_ready = done & owner_q;
  assign i_rdata = i_ready ? mem_rdata : 32'h0;
  assign d_rdata = d_ready ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table for the basic flows plus
// hand-written sequences for starvation, reset abort and LATENCY=1.
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [2:0]  d_access_type;

  logic        i_ready, d_ready, mem_en, mem_wren, busy, owner_d;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [2:0]  mem_access_type;

  logic        i_ready1, d_ready1, mem_en1, mem_wren1, busy1, owner_d1;
  logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1;
  logic [2:0]  mem_access_type1;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.LATENCY(2), .MAX_DSTREAK(3)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_access_type(d_access_type), .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_access_type(mem_access_type), .mem_rdata(mem_rdata),
    .busy(busy), .owner_d(owner_d)
  );

  mem_arbiter #(.LATENCY(1), .MAX_DSTREAK(3)) dut1 (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready1), .i_rdata(i_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_access_type(d_access_type), .d_ready(d_ready1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_wren(mem_wren1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_access_type(mem_access_type1), .mem_rdata(mem_rdata),
    .busy(busy1), .owner_d(owner_d1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [2:0]  dt;
    logic [31:0] mrd;
    logic        en;
    logic        wren;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [2:0]  mt;
    logic        irdy;
    logic [31:0] ird;
    logic        drdy;
    logic [31:0] drd;
    logic        bsy;
    logic        own;
  } vec_t;

  localparam int NV = 14;
  localparam logic [31:0] Z = 32'h0;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  logic [7:0] exp_own;
  logic [7:0] got_own;

  initial begin
    // fetch 0x40; address changes during ISSUE/WAIT are ignored
    tbl[0]  = '{1'b1,32'h40,1'b0,1'b0,Z,Z,3'd0,Z,           1'b0,1'b0,Z,Z,3'd0,1'b0,Z,1'b0,Z,1'b0,1'b0};
    tbl[1]  = '{1'b1,32'h44,1'b0,1'b0,Z,Z,3'd0,Z,           1'b1,1'b0,32'h40,Z,3'd2,1'b0,Z,1'b0,Z,1'b1,1'b0};
    tbl[2]  = '{1'b1,32'h44,1'b0,1'b0,Z,Z,3'd0,Z,           1'b0,1'b0,32'h40,Z,3'd2,1'b0,Z,1'b0,Z,1'b1,1'b0};
    tbl[3]  = '{1'b1,32'h44,1'b0,1'b0,Z,Z,3'd0,32'h11112222, 1'b0,1'b0,32'h40,Z,3'd2,1'b1,32'h11112222,1'b0,Z,1'b1,1'b0};
    tbl[4]  = '{1'b0,Z,1'b0,1'b0,Z,Z,3'd0,32'h11112222,     1'b0,1'b0,Z,Z,3'd0,1'b0,Z,1'b0,Z,1'b0,1'b0};
    // simultaneous requests: store wins, then the fetch
    tbl[5]  = '{1'b1,32'h80,1'b1,1'b1,32'h100,32'hDEADBEEF,3'd2,Z, 1'b0,1'b0,Z,Z,3'd0,1'b0,Z,1'b0,Z,1'b0,1'b0};
    tbl[6]  = '{1'b1,32'h80,1'b1,1'b1,32'h100,32'hDEADBEEF,3'd2,Z, 1'b1,1'b1,32'h100,32'hDEADBEEF,3'd2,1'b0,Z,1'b0,Z,1'b1,1'b1};
    tbl[7]  = '{1'b1,32'h80,1'b1,1'b1,32'h104,32'hDEADBEEF,3'd2,Z, 1'b0,1'b0,32'h100,32'hDEADBEEF,3'd2,1'b0,Z,1'b0,Z,1'b1,1'b1};
    tbl[8]  = '{1'b1,32'h80,1'b1,1'b1,32'h104,32'hDEADBEEF,3'd2,Z, 1'b0,1'b0,32'h100,32'hDEADBEEF,3'd2,1'b0,Z,1'b1,Z,1'b1,1'b1};
    tbl[9]  = '{1'b1,32'h80,1'b0,1'b1,Z,Z,3'd0,Z,           1'b0,1'b0,Z,Z,3'd0,1'b0,Z,1'b0,Z,1'b0,1'b0};
    tbl[10] = '{1'b1,32'h80,1'b0,1'b1,Z,Z,3'd0,Z,           1'b1,1'b0,32'h80,Z,3'd2,1'b0,Z,1'b0,Z,1'b1,1'b0};
    tbl[11] = '{1'b1,32'h80,1'b0,1'b1,Z,Z,3'd0,Z,           1'b0,1'b0,32'h80,Z,3'd2,1'b0,Z,1'b0,Z,1'b1,1'b0};
    tbl[12] = '{1'b1,32'h80,1'b0,1'b1,Z,Z,3'd0,32'h12345678, 1'b0,1'b0,32'h80,Z,3'd2,1'b1,32'h12345678,1'b0,Z,1'b1,1'b0};
    tbl[13] = '{1'b0,Z,1'b0,1'b0,Z,Z,3'd0,32'h12345678,     1'b0,1'b0,Z,Z,3'd0,1'b0,Z,1'b0,Z,1'b0,1'b0};

    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = Z; d_addr = Z; d_wdata = Z; mem_rdata = Z; d_access_type = 3'd0;

    // reset state
    reset = 1'b1;
    next_cycle();
    @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner_d", 32'(owner_d), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_wren", 32'(mem_wren), 32'd0);
    chk("rst_mem_addr", mem_addr, Z);
    chk("rst_readies", 32'({i_ready, d_ready}), 32'd0);
    chk("rst_rdatas", i_rdata | d_rdata, Z);
    next_cycle();
    reset = 1'b0;

    for (int k = 0; k < NV; k++) begin
      i_req = tbl[k].ir; i_addr = tbl[k].ia;
      d_req = tbl[k].dr; d_we = tbl[k].dwe; d_addr = tbl[k].da;
      d_wdata = tbl[k].dwd; d_access_type = tbl[k].dt; mem_rdata = tbl[k].mrd;
      @(negedge clock);
      chk($sformatf("v%0d_mem_en", k), 32'(mem_en), 32'(tbl[k].en));
      chk($sformatf("v%0d_mem_wren", k), 32'(mem_wren), 32'(tbl[k].wren));
      chk($sformatf("v%0d_i_ready", k), 32'(i_ready), 32'(tbl[k].irdy));
      chk($sformatf("v%0d_i_rdata", k), i_rdata, tbl[k].ird);
      chk($sformatf("v%0d_d_ready", k), 32'(d_ready), 32'(tbl[k].drdy));
      chk($sformatf("v%0d_d_rdata", k), d_rdata, tbl[k].drd);
      chk($sformatf("v%0d_busy", k), 32'(busy), 32'(tbl[k].bsy));
      chk($sformatf("v%0d_owner_d", k), 32'(owner_d), 32'(tbl[k].own));
      if (tbl[k].bsy) begin
        chk($sformatf("v%0d_mem_addr", k), mem_addr, tbl[k].maddr);
        chk($sformatf("v%0d_mem_wdata", k), mem_wdata, tbl[k].mwd);
        chk($sformatf("v%0d_mem_type", k), 32'(mem_access_type), 32'(tbl[k].mt));
      end
      next_cycle();
    end

    // starvation limit with both requests held across reset release
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 32'h1000; d_addr = 32'h2000; d_access_type = 3'b100; mem_rdata = 32'h0BADF00D;
    reset_dut();
    begin
      int grants;
      int last_en;
      grants = 0;
      last_en = 0;
      got_own = 8'h00;
      exp_own = 8'b0111_0111;
      for (int cyc = 0; cyc < 100 && grants < 8; cyc++) begin
        @(negedge clock);
        chk("starve_dual_ready", 32'(i_ready & d_ready), 32'd0);
        if (mem_en) begin
          got_own[grants] = owner_d;
          if (grants == 0) chk("starve_first_grant_cycle", 32'(cyc), 32'd1);
          else             chk("starve_grant_spacing", 32'(cyc - last_en), 32'd4);
          last_en = cyc;
          grants++;
        end
        next_cycle();
      end
      chk("starve_grant_count", 32'(grants), 32'd8);
      chk("starve_grant_order", 32'(got_own), 32'(exp_own));
    end

    // reset during WAIT aborts the load; held d_req is reissued
    i_req = 1'b0; d_req = 1'b0;
    reset_dut();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_access_type = 3'b000; mem_rdata = 32'h5555AAAA;
    @(negedge clock);
    chk("rwait_idle_en", 32'(mem_en), 32'd0);
    next_cycle();
    @(negedge clock);
    chk("rwait_issue_en", 32'(mem_en), 32'd1);
    next_cycle();
    reset = 1'b1;
    @(negedge clock);
    chk("rwait_no_ready_in_reset", 32'(d_ready), 32'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    chk("rwait_after_d_ready", 32'(d_ready), 32'd0);
    chk("rwait_after_busy", 32'(busy), 32'd0);
    chk("rwait_after_mem_en", 32'(mem_en), 32'd0);
    chk("rwait_after_mem_addr", mem_addr, Z);
    chk("rwait_after_owner", 32'(owner_d), 32'd0);
    next_cycle();
    @(negedge clock);
    chk("rwait_reissue_en", 32'(mem_en), 32'd1);
    chk("rwait_reissue_addr", mem_addr, 32'h200);
    chk("rwait_reissue_owner", 32'(owner_d), 32'd1);
    next_cycle();
    @(negedge clock);
    chk("rwait_reissue_early_ready", 32'(d_ready), 32'd0);
    next_cycle();
    @(negedge clock);
    chk("rwait_reissue_ready", 32'(d_ready), 32'd1);
    chk("rwait_reissue_rdata", d_rdata, 32'h5555AAAA);
    next_cycle();
    d_req = 1'b0;

    // LATENCY=1 instance: one-cycle request still completes
    reset_dut();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; mem_rdata = 32'hA5A5A5A5;
    @(negedge clock);
    chk("lat1_c0_rdatas", i_rdata1 | d_rdata1, Z);
    chk("lat1_c0_d_ready", 32'(d_ready1), 32'd0);
    next_cycle();
    d_req = 1'b0;
    @(negedge clock);
    chk("lat1_c1_mem_en", 32'(mem_en1), 32'd1);
    chk("lat1_c1_mem_addr", mem_addr1, 32'h300);
    chk("lat1_c1_rdatas", i_rdata1 | d_rdata1, Z);
    chk("lat1_c1_d_ready", 32'(d_ready1), 32'd0);
    next_cycle();
    @(negedge clock);
    chk("lat1_c2_d_ready", 32'(d_ready1), 32'd1);
    chk("lat1_c2_d_rdata", d_rdata1, 32'hA5A5A5A5);
    chk("lat1_c2_i_ready", 32'(i_ready1), 32'd0);
    chk("lat1_c2_i_rdata", i_rdata1, Z);
    next_cycle();
    @(negedge clock);
    chk("lat1_c3_d_ready", 32'(d_ready1), 32'd0);
    chk("lat1_c3_rdatas", i_rdata1 | d_rdata1, Z);
    chk("lat1_c3_busy", 32'(busy1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
